// File: rtl/stream_rr_sched_pkg.sv
// Shared helpers for the round-robin stream scheduler.
package stream_rr_sched_pkg;

  // Index width for a count of items; never narrower than one bit.
  function automatic int unsigned idx_width(input int unsigned num);
    return (num > 32'd1) ? unsigned'($clog2(num)) : 32'd1;
  endfunction

endpackage

// File: rtl/stream_rr_pick.sv
// Cyclic priority encoder: first valid index at or after start_i, wrapping.
module stream_rr_pick #(
  parameter int unsigned NumInp = 4,
  parameter int unsigned IdxW   = 2
) (
  input  logic [NumInp-1:0] valid_i,
  input  logic [IdxW-1:0]   start_i,
  output logic [IdxW-1:0]   idx_o,
  output logic              any_o
);

  int cand;

  // Scan from the farthest offset down so the nearest valid index wins last.
  always_comb begin
    idx_o = start_i;
    cand  = 0;
    for (int k = int'(NumInp) - 1; k >= 0; k--) begin
      cand = int'(start_i) + k;
      if (cand >= int'(NumInp)) cand = cand - int'(NumInp);
      if (valid_i[cand[IdxW-1:0]]) idx_o = cand[IdxW-1:0];
    end
  end

  assign any_o = |valid_i;

endmodule

// File: rtl/stream_rr_sched.sv
// Round-robin scheduler sharing one ready/valid sink among NumInp sources,
// with per-grant burst allowance, stall lock and saturating transfer counters.
module stream_rr_sched
  import stream_rr_sched_pkg::*;
#(
  parameter type          data_t   = logic,
  parameter int unsigned  NumInp   = 4,
  parameter int unsigned  MaxBurst = 1,
  parameter int unsigned  CntWidth = 32,
  localparam int unsigned IdxW     = idx_width(NumInp)
) (
  input  logic                             clk_i,
  input  logic                             rst_ni,
  input  data_t [NumInp-1:0]               inp_data_i,
  input  logic  [NumInp-1:0]               inp_valid_i,
  output logic  [NumInp-1:0]               inp_ready_o,
  output data_t                            oup_data_o,
  output logic                             oup_valid_o,
  input  logic                             oup_ready_i,
  output logic  [IdxW-1:0]                 oup_idx_o,
  input  logic                             clr_cnt_i,
  output logic  [NumInp-1:0][CntWidth-1:0] xfer_cnt_o
);

  localparam int unsigned     BurstW    = idx_width(MaxBurst);
  localparam logic [BurstW-1:0] BurstLast = BurstW'(MaxBurst - 1);
  localparam logic [IdxW-1:0] LastIdx   = IdxW'(NumInp - 1);

  logic [IdxW-1:0]   prio_q, prio_d, lock_idx_q, lock_idx_d;
  logic [IdxW-1:0]   scan_idx, grant;
  logic [BurstW-1:0] burst_q, burst_d, burst_eff;
  logic              lock_q, lock_d, scan_any, hs, others_valid;
  logic [NumInp-1:0] grant_oh;
  logic [NumInp-1:0][CntWidth-1:0] cnt_q, cnt_d;

  stream_rr_pick #(
    .NumInp (NumInp),
    .IdxW   (IdxW)
  ) u_pick (
    .valid_i (inp_valid_i),
    .start_i (prio_q),
    .idx_o   (scan_idx),
    .any_o   (scan_any)
  );

  // Handshake: a transfer happens in a cycle where oup_valid_o and oup_ready_i
  // are both high; an offered-but-stalled beat locks the grant until it does.
  always_comb begin
    grant           = lock_q ? lock_idx_q : scan_idx;
    grant_oh        = '0;
    grant_oh[grant] = 1'b1;
    oup_data_o      = inp_data_i[grant];
    oup_valid_o     = inp_valid_i[grant];
    oup_idx_o       = grant;
    inp_ready_o     = scan_any ? (grant_oh & {NumInp{oup_ready_i}}) : '0;
    hs              = oup_valid_o & oup_ready_i;
    others_valid    = |(inp_valid_i & ~grant_oh);
  end

  always_comb begin
    prio_d     = prio_q;
    burst_d    = burst_q;
    lock_d     = oup_valid_o & ~oup_ready_i;
    lock_idx_d = lock_d ? grant : lock_idx_q;
    // A burst only continues if the grant stayed on the prioritised source.
    burst_eff  = (grant == prio_q) ? burst_q : '0;
    if (hs) begin
      if ((burst_eff == BurstLast) || !others_valid) begin
        burst_d = '0;
        prio_d  = (grant == LastIdx) ? '0 : grant + IdxW'(1);
      end else begin
        burst_d = burst_eff + BurstW'(1);
        prio_d  = grant;
      end
    end
    for (int i = 0; i < int'(NumInp); i++) begin
      cnt_d[i] = cnt_q[i];
      if (clr_cnt_i) begin
        cnt_d[i] = '0;
      end else if (hs && grant_oh[i] && (cnt_q[i] != '1)) begin
        cnt_d[i] = cnt_q[i] + CntWidth'(1);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      prio_q     <= '0;
      burst_q    <= '0;
      lock_q     <= 1'b0;
      lock_idx_q <= '0;
      cnt_q      <= '0;
    end else begin
      prio_q     <= prio_d;
      burst_q    <= burst_d;
      lock_q     <= lock_d;
      lock_idx_q <= lock_idx_d;
      cnt_q      <= cnt_d;
    end
  end

  assign xfer_cnt_o = cnt_q;

  // A source must keep valid high until its offered beat is accepted.
  assert property (@(posedge clk_i) disable iff (!rst_ni) lock_q |-> inp_valid_i[lock_idx_q])
    else $error("stream_rr_sched: locked source %0d retracted valid", lock_idx_q);

endmodule
